// File: rtl/cordic_pkg.sv
// Constants shared by the rotation-mode and vectoring-mode CORDIC blocks.
// Angles are 32-bit binary angles: 2^32 is one full turn.
package cordic_pkg;

  localparam logic [31:0] ANGLE_90        = 32'h4000_0000;
  localparam logic [31:0] ANGLE_M90       = 32'hC000_0000;
  localparam logic [31:0] CORDIC_INV_GAIN = 32'h4DBA_76D4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t LOAD    = 2'd1;
  localparam state_t ITERATE = 2'd2;
  localparam state_t FINISH  = 2'd3;

  // atan(2^-i) / (2*pi) * 2^32, rounded; entry 31 rounds to zero
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: steers y toward zero and accumulates the
// rotated angle into z. Purely combinational; the top reuses it every cycle.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [33:0] i_x,
  input  logic signed [33:0] i_y,
  input  logic        [31:0] i_z,
  input  logic        [4:0]  i_iter,
  output logic signed [33:0] o_x,
  output logic signed [33:0] o_y,
  output logic        [31:0] o_z
);

  logic signed [33:0] w_xs;
  logic signed [33:0] w_ys;
  logic        [31:0] w_atan;

  assign w_xs   = i_x >>> i_iter;
  assign w_ys   = i_y >>> i_iter;
  assign w_atan = ATAN_TABLE[i_iter];

  always_comb begin
    if (!i_y[33]) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + w_atan;
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - w_atan;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2 binary angle and magnitude.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K (one extra cycle).
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic [31:0] angle_out,
  output logic [33:0] mag_out,
  output logic        busy,
  output logic        done
);

  state_t             r_state;
  logic signed [33:0] r_x;
  logic signed [33:0] r_y;
  logic        [31:0] r_z;
  logic        [4:0]  r_count;
  logic               r_zero;
  logic        [31:0] r_angle;
  logic        [33:0] r_mag;
  logic               r_busy;
  logic               r_done;

  logic signed [33:0] w_x;
  logic signed [33:0] w_y;
  logic        [31:0] w_z;

  cordic_vec_stage u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_iter (r_count),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_z    (w_z)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic        r_fin;
  logic [33:0] w_scaled;
  // x is non-negative after convergence, so an unsigned Q1.31 multiply is safe
  assign w_scaled = 34'((66'(r_x) * 66'(CORDIC_INV_GAIN)) >> 31);
`endif

  // A zero vector has no defined direction, so its angle is forced to zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
      r_fin   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= {{2{x_in[31]}}, x_in};
            r_y     <= {{2{y_in[31]}}, y_in};
            r_zero  <= (x_in == 32'd0) && (y_in == 32'd0);
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // Fold the left half-plane onto the right; negation at 34 bits cannot overflow
          if (!r_x[33]) begin
            r_z <= '0;
          end else if (!r_y[33]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= ANGLE_90;
          end else begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= ANGLE_M90;
          end
          r_count <= '0;
          r_state <= ITERATE;
        end
        ITERATE: begin
          r_x     <= w_x;
          r_y     <= w_y;
          r_z     <= w_z;
          r_count <= r_count + 5'd1;
          if (r_count == 5'(ITER - 1)) r_state <= FINISH;
        end
        FINISH: begin
`ifdef CORDIC_GAIN_COMP_EN
          if (!r_fin) begin
            r_x   <= w_scaled;
            r_fin <= 1'b1;
          end else begin
            r_fin   <= 1'b0;
            r_angle <= r_zero ? 32'd0 : r_z;
            r_mag   <= r_x;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
`else
          r_angle <= r_zero ? 32'd0 : r_z;
          r_mag   <= r_x;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign angle_out = r_angle;
  assign mag_out   = r_mag;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector against a real-arithmetic atan2/hypot model.
// Honours CORDIC_GAIN_COMP_EN for the expected latency and magnitude gain.
module tb_cordic_vector;

  localparam int ITER = 30;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam int  LAT     = ITER + 2 + (COMP ? 1 : 0);
  localparam int  ANG_TOL = 64;
  localparam real MAG_TOL = 16.0;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] angle_out;
  logic [33:0] mag_out;
  logic        busy;
  logic        done;

  int total;
  int bad;

  cordic_vector #(.ITER(ITER)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_angle(input logic [31:0] xv, input logic [31:0] yv);
    int     xi, yi;
    real    xr, yr, a;
    longint q;
    xi = $signed(xv);
    yi = $signed(yv);
    xr = xi;
    yr = yi;
    a  = $atan2(yr, xr) * 4294967296.0 / (2.0 * 3.14159265358979323846);
    q  = longint'(a);
    return q[31:0];
  endfunction

  function automatic real ref_mag(input logic [31:0] xv, input logic [31:0] yv);
    int  xi, yi;
    real xr, yr, k, p;
    xi = $signed(xv);
    yi = $signed(yv);
    xr = xi;
    yr = yi;
    k  = 1.0;
    p  = 1.0;
    if (!COMP) begin
      for (int i = 0; i < ITER; i++) begin
        k = k * $sqrt(1.0 + p);
        p = p * 0.25;
      end
    end
    return k * $sqrt(xr * xr + yr * yr);
  endfunction

  function automatic real mag_real(input logic [33:0] m);
    longint l;
    real    r;
    l = longint'({30'd0, m});
    r = l;
    return r;
  endfunction

  function automatic int ang_diff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return $signed(d);
  endfunction

  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                        output int lat, output logic [31:0] ang, output logic [33:0] mag);
    @(negedge clock);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 20 && lat < 0; k++) begin
      @(negedge clock);
      if (done) lat = k;
    end
    ang = angle_out;
    mag = mag_out;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (2) @(negedge clock);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++;
    if (angle_out !== 32'd0) begin bad++; $display("FAIL reset_angle: got %h want 0", angle_out); end
    total++;
    if (mag_out !== 34'd0) begin bad++; $display("FAIL reset_mag: got %h want 0", mag_out); end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] xs [5];
    logic [31:0] ys [5];
    logic [31:0] as [5];
    logic [31:0] ang;
    logic [33:0] mag;
    int          lat, d, tol;
    real         mr, me, mtol;
    xs = '{32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000};
    ys = '{32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 32'h0000_0000, 32'h0000_0000};
    as = '{32'h0000_0000, 32'hC000_0000, 32'hA000_0000, 32'h8000_0000, 32'h0000_0000};
    for (int n = 0; n < 5; n++) begin
      run_op(xs[n], ys[n], lat, ang, mag);
      tol  = (xs[n] == 32'd0 && ys[n] == 32'd0) ? 0 : ANG_TOL;
      mtol = (xs[n] == 32'd0 && ys[n] == 32'd0) ? 0.0 : MAG_TOL;
      total++;
      if (lat != LAT) begin
        bad++; $display("FAIL dir%0d_latency: got %0d want %0d", n, lat, LAT);
      end
      d = ang_diff(ang, as[n]);
      total++;
      if (d > tol || d < -tol) begin
        bad++; $display("FAIL dir%0d_angle: got %h want %h +/-%0d", n, ang, as[n], tol);
      end
      mr = mag_real(mag);
      me = ref_mag(xs[n], ys[n]);
      total++;
      if (mr - me > mtol || me - mr > mtol) begin
        bad++; $display("FAIL dir%0d_mag: got %0.1f want %0.1f", n, mr, me);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] xv, yv, ang, ae;
    logic [33:0] mag;
    int          lat, d;
    real         mr, me;
    for (int n = 0; n < 20; n++) begin
      do begin
        xv = $urandom;
        yv = $urandom;
      end while ((xv[31:28] == 4'h0 || xv[31:28] == 4'hF) &&
                 (yv[31:28] == 4'h0 || yv[31:28] == 4'hF));
      run_op(xv, yv, lat, ang, mag);
      total++;
      if (lat != LAT) begin
        bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, LAT);
      end
      ae = ref_angle(xv, yv);
      d  = ang_diff(ang, ae);
      total++;
      if (d > ANG_TOL || d < -ANG_TOL) begin
        bad++; $display("FAIL rnd%0d_angle: x=%h y=%h got %h want %h", n, xv, yv, ang, ae);
      end
      mr = mag_real(mag);
      me = ref_mag(xv, yv);
      total++;
      if (mr - me > MAG_TOL || me - mr > MAG_TOL) begin
        bad++; $display("FAIL rnd%0d_mag: x=%h y=%h got %0.1f want %0.1f", n, xv, yv, mr, me);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] ax, ay, ang, ae;
    logic [33:0] mag;
    int          first, ndone, d;
    real         mr, me;
    ax = 32'h3000_0000;
    ay = 32'h1000_0000;
    first = -1;
    ndone = 0;
    ang = '0;
    mag = '0;
    @(negedge clock);
    x_in  = ax;
    y_in  = ay;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 2 * LAT + 10; k++) begin
      if (k == 5) begin
        x_in  = 32'h9000_0000;
        y_in  = 32'h7000_0000;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      @(negedge clock);
      if (k == 3) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_op: got %b want 1", busy); end
      end
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          ang   = angle_out;
          mag   = mag_out;
        end
      end
    end
    total++;
    if (first != LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", first, LAT); end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    ae = ref_angle(ax, ay);
    d  = ang_diff(ang, ae);
    total++;
    if (d > ANG_TOL || d < -ANG_TOL) begin
      bad++; $display("FAIL ignore_angle: got %h want %h", ang, ae);
    end
    mr = mag_real(mag);
    me = ref_mag(ax, ay);
    total++;
    if (mr - me > MAG_TOL || me - mr > MAG_TOL) begin
      bad++; $display("FAIL ignore_mag: got %0.1f want %0.1f", mr, me);
    end
    d = ang_diff(angle_out, ae);
    total++;
    if (d > ANG_TOL || d < -ANG_TOL) begin
      bad++; $display("FAIL ignore_hold_angle: got %h want %h", angle_out, ae);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ax, ay, bx, by, ang1, ang2, ae;
    logic [33:0] mag2;
    int          k1, k2, ndone, d;
    real         mr, me;
    ax = 32'h2000_0000;  ay = 32'hE000_0000;
    bx = 32'hD000_0000;  by = 32'h4000_0000;
    k1 = -1; k2 = -1; ndone = 0;
    ang1 = '0; ang2 = '0; mag2 = '0;
    @(negedge clock);
    x_in  = ax;
    y_in  = ay;
    start = 1'b1;
    for (int k = 0; k <= 2 * LAT + 10; k++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (k1 < 0) begin
          k1   = k;
          ang1 = angle_out;
          x_in = bx;
          y_in = by;
          total++;
          if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_done: got %b want 0", busy); end
        end else if (k2 < 0) begin
          k2   = k;
          ang2 = angle_out;
          mag2 = mag_out;
        end
      end
      if (k1 >= 0 && k == k1 + 1) begin
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_relaunch_busy: got %b want 1", busy); end
      end
    end
    start = 1'b0;
    total++;
    if (k1 != LAT) begin bad++; $display("FAIL b2b_first_done: got %0d want %0d", k1, LAT); end
    total++;
    if (k2 != 2 * LAT + 1) begin bad++; $display("FAIL b2b_second_done: got %0d want %0d", k2, 2 * LAT + 1); end
    total++;
    if (ndone != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    ae = ref_angle(ax, ay);
    d  = ang_diff(ang1, ae);
    total++;
    if (d > ANG_TOL || d < -ANG_TOL) begin bad++; $display("FAIL b2b_angle1: got %h want %h", ang1, ae); end
    ae = ref_angle(bx, by);
    d  = ang_diff(ang2, ae);
    total++;
    if (d > ANG_TOL || d < -ANG_TOL) begin bad++; $display("FAIL b2b_angle2: got %h want %h", ang2, ae); end
    mr = mag_real(mag2);
    me = ref_mag(bx, by);
    total++;
    if (mr - me > MAG_TOL || me - mr > MAG_TOL) begin
      bad++; $display("FAIL b2b_mag2: got %0.1f want %0.1f", mr, me);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    @(negedge clock);
    x_in  = 32'h2000_0000;
    y_in  = 32'h5000_0000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    total++;
    if (angle_out !== 32'd0) begin bad++; $display("FAIL abort_angle: got %h want 0", angle_out); end
    total++;
    if (mag_out !== 34'd0) begin bad++; $display("FAIL abort_mag: got %h want 0", mag_out); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    total++;
    if (angle_out !== 32'd0) begin bad++; $display("FAIL abort_hold_angle: got %h want 0", angle_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
